fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 13 +
 rtl/ret_stack.sv | 38 +++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned IW_DEFAULT        = 9;
    localparam int unsigned RAS_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: LIFO with full/empty flags and synchronous clear.
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 9
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Top-of-stack is the most recent push; only meaningful when not empty.
    assign dout  = mem[AW'(count - CW'(1))];

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            mem[AW'(count)] <= din;
            count           <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the ROM address with branch, jump,
// call/return and stall/halt control, using a small return-address stack.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned IW        = IW_DEFAULT,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchTaken,
    input  logic [7:0]    BranchOffset,
    input  logic          JumpEn,
    input  logic          CallEn,
    input  logic          RetEn,
    input  logic [IW-1:0] JumpTarget,
    output logic [IW-1:0] InstAddress,
    output logic          InstValid,
    output logic          Done,
    output logic          RasErr
);

    state_t        state;
    logic [IW-1:0] pc;
    logic [IW-1:0] pc_inc;
    logic [IW-1:0] pc_br;
    logic [IW-1:0] ras_top;
    logic          ras_full;
    logic          ras_empty;
    logic          ras_clear;
    logic          ras_push;
    logic          ras_pop;
    logic          run_go;

    assign pc_inc = pc + IW'(1);
    assign pc_br  = pc + IW'($signed(BranchOffset));

    // Control inputs only act in an unstalled, non-halting RUN cycle.
    assign run_go    = (state == RUN) && !Halt && !Stall;
    assign ras_pop   = run_go && RetEn && !ras_empty;
    assign ras_push  = run_go && !RetEn && CallEn && !ras_full;
    assign ras_clear = Reset || ((state != RUN) && Start);

    assign InstAddress = pc;
    assign InstValid   = (state == RUN) && !Stall;

    ret_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (IW)
    ) u_ras (
        .clk   (CLK),
        .clear (ras_clear),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .dout  (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= IDLE;
            pc     <= '0;
            Done   <= 1'b0;
            RasErr <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state  <= RUN;
                        pc     <= '0;
                        Done   <= 1'b0;
                        RasErr <= 1'b0;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else if (!Stall) begin
                        if (RetEn) begin
                            if (ras_empty) begin
                                pc     <= pc_inc;
                                RasErr <= 1'b1;
                            end else begin
                                pc <= ras_top;
                            end
                        end else if (CallEn) begin
                            pc <= JumpTarget;
                            if (ras_full) begin
                                RasErr <= 1'b1;
                            end
                        end else if (JumpEn) begin
                            pc <= JumpTarget;
                        end else if (BranchTaken) begin
                            pc <= pc_br;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pc    <= '0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, corner sequences,
// and random stimulus against a queue-based behavioural model.
module tb_fetch_sequencer;

    localparam int unsigned IW = 9;
    localparam int D = 4;
    localparam int N = 1 << IW;

    logic          clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic          Stall = 1'b0;
    logic          Halt = 1'b0;
    logic          BranchTaken = 1'b0;
    logic [7:0]    BranchOffset = 8'h00;
    logic          JumpEn = 1'b0;
    logic          CallEn = 1'b0;
    logic          RetEn = 1'b0;
    logic [IW-1:0] JumpTarget = '0;
    logic [IW-1:0] InstAddress;
    logic          InstValid;
    logic          Done;
    logic          RasErr;

    fetch_sequencer #(.IW(IW), .RAS_DEPTH(D)) dut (
        .CLK          (clk),
        .Reset        (Reset),
        .Start        (Start),
        .Stall        (Stall),
        .Halt         (Halt),
        .BranchTaken  (BranchTaken),
        .BranchOffset (BranchOffset),
        .JumpEn       (JumpEn),
        .CallEn       (CallEn),
        .RetEn        (RetEn),
        .JumpTarget   (JumpTarget),
        .InstAddress  (InstAddress),
        .InstValid    (InstValid),
        .Done         (Done),
        .RasErr       (RasErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, start, stall, halt, br;
        logic [7:0] off;
        bit       jmp, call, ret;
        int       tgt;
        bit       cv;   // check InstValid for this vector
        bit       ev;   // expected InstValid with these inputs, before the edge
        int       ea;   // expected InstAddress after the edge
        bit       ed;
        bit       ee;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Behavioural model: 0=idle 1=run 2=done, PC as integer, stack as queue.
    int m_st = 0;
    int m_pc = 0;
    int m_stk[$];
    bit m_err = 1'b0;

    function automatic vec_t mk(bit rst, bit start, bit stall, bit halt, bit br,
                                logic [7:0] off, bit jmp, bit call, bit ret, int tgt,
                                bit cv, bit ev, int ea, bit ed, bit ee);
        vec_t v;
        v.rst = rst; v.start = start; v.stall = stall; v.halt = halt; v.br = br;
        v.off = off; v.jmp = jmp; v.call = call; v.ret = ret; v.tgt = tgt;
        v.cv = cv; v.ev = ev; v.ea = ea; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(string tag, vec_t v);
        Reset = v.rst; Start = v.start; Stall = v.stall; Halt = v.halt;
        BranchTaken = v.br; BranchOffset = v.off; JumpEn = v.jmp;
        CallEn = v.call; RetEn = v.ret; JumpTarget = IW'(v.tgt);
        #1;
        if (v.cv) chk({tag, ".valid"}, int'(InstValid), int'(v.ev));
        @(posedge clk);
        #1;
        chk({tag, ".addr"}, int'(InstAddress), v.ea);
        chk({tag, ".done"}, int'(Done), int'(v.ed));
        chk({tag, ".raserr"}, int'(RasErr), int'(v.ee));
    endtask

    task automatic model_step(vec_t v);
        if (v.rst) begin
            m_st = 0; m_pc = 0; m_stk.delete(); m_err = 1'b0;
        end else if (m_st != 1) begin
            if (v.start) begin
                m_st = 1; m_pc = 0; m_stk.delete(); m_err = 1'b0;
            end
        end else if (v.halt) begin
            m_st = 2;
        end else if (!v.stall) begin
            if (v.ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = (m_pc + 1) % N; m_err = 1'b1; end
            end else if (v.call) begin
                if (m_stk.size() < D) m_stk.push_back((m_pc + 1) % N);
                else m_err = 1'b1;
                m_pc = v.tgt;
            end else if (v.jmp) begin
                m_pc = v.tgt;
            end else if (v.br) begin
                m_pc = ((m_pc + int'($signed(v.off))) % N + N) % N;
            end else begin
                m_pc = (m_pc + 1) % N;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;

        // Directed table, starting right after a reset.
        tbl.push_back(mk(0,1,0,0,0,8'h00,0,0,0,0,   1,0,  0,0,0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(0,0,0,0,0,8'h00,0,0,0,0, 1,1, k,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,0,0,10,  1,1, 10,0,0));
        tbl.push_back(mk(0,0,0,0,1,8'hFD,0,0,0,0,   1,1,  7,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,0,0,511, 1,1,511,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,0,0,0,0,   1,1,  0,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,0,0,5,   1,1,  5,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,0,1,0,100, 1,1,100,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,0,0,1,0,   1,1,  6,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,0,0,1,0,   1,1,  7,0,1));
        tbl.push_back(mk(0,1,0,0,0,8'h00,0,0,0,0,   1,1,  8,0,1));
        tbl.push_back(mk(0,0,1,0,0,8'h00,1,0,0,50,  1,0,  8,0,1));
        tbl.push_back(mk(0,0,0,1,0,8'h00,0,0,0,0,   1,1,  8,1,1));
        tbl.push_back(mk(0,0,0,0,1,8'h10,1,1,1,3,   1,0,  8,1,1));
        tbl.push_back(mk(0,1,0,0,0,8'h00,0,0,0,0,   1,0,  0,0,0));
        tbl.push_back(mk(0,0,0,0,1,8'h05,1,0,0,20,  1,1, 20,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00,0,1,1,30,  1,1, 21,0,1));
        tbl.push_back(mk(0,0,0,0,1,8'h7F,0,0,0,0,   1,1,148,0,1));
        tbl.push_back(mk(0,0,0,0,1,8'h80,0,0,0,0,   1,1, 20,0,1));
        tbl.push_back(mk(0,0,0,0,0,8'h00,1,0,0,510, 1,1,510,0,1));
        tbl.push_back(mk(0,0,0,0,1,8'h05,0,0,0,0,   1,1,  3,0,1));

        run_vec("reset", mk(1,0,0,0,0,8'h00,0,0,0,0, 0,0, 0,0,0));
        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Nested calls overflowing a four-entry stack, then unwinding past empty.
        run_vec("nest.rst",   mk(1,0,0,0,0,8'h00,0,0,0,0,  0,0,  0,0,0));
        run_vec("nest.start", mk(0,1,0,0,0,8'h00,0,0,0,0,  1,0,  0,0,0));
        run_vec("nest.c1",    mk(0,0,0,0,0,8'h00,0,1,0,10, 1,1, 10,0,0));
        run_vec("nest.c2",    mk(0,0,0,0,0,8'h00,0,1,0,20, 1,1, 20,0,0));
        run_vec("nest.c3",    mk(0,0,0,0,0,8'h00,0,1,0,30, 1,1, 30,0,0));
        run_vec("nest.c4",    mk(0,0,0,0,0,8'h00,0,1,0,40, 1,1, 40,0,0));
        run_vec("nest.c5",    mk(0,0,0,0,0,8'h00,0,1,0,50, 1,1, 50,0,1));
        run_vec("nest.r1",    mk(0,0,0,0,0,8'h00,0,0,1,0,  1,1, 31,0,1));
        run_vec("nest.r2",    mk(0,0,0,0,0,8'h00,0,0,1,0,  1,1, 21,0,1));
        run_vec("nest.r3",    mk(0,0,0,0,0,8'h00,0,0,1,0,  1,1, 11,0,1));
        run_vec("nest.r4",    mk(0,0,0,0,0,8'h00,0,0,1,0,  1,1,  1,0,1));
        run_vec("nest.r5",    mk(0,0,0,0,0,8'h00,0,0,1,0,  1,1,  2,0,1));

        // Stalled jumps are ignored; Halt wins over Stall.
        for (int k = 0; k < 3; k++)
            run_vec($sformatf("stall%0d", k), mk(0,0,1,0,0,8'h00,1,0,0,9, 1,0, 2,0,1));
        run_vec("stall.halt", mk(0,0,1,1,0,8'h00,0,0,0,0, 1,0, 2,1,1));
        run_vec("stall.done", mk(0,0,0,0,0,8'h00,0,0,0,0, 1,0, 2,1,1));

        // Reset mid-run with a pending call clears state, PC, flag and stack.
        run_vec("mid.start", mk(0,1,0,0,0,8'h00,0,0,0,0,  1,0,  0,0,0));
        run_vec("mid.ret0",  mk(0,0,0,0,0,8'h00,0,0,1,0,  1,1,  1,0,1));
        run_vec("mid.call",  mk(0,0,0,0,0,8'h00,0,1,0,40, 1,1, 40,0,1));
        run_vec("mid.jmp",   mk(0,0,0,0,0,8'h00,1,0,0,37, 1,1, 37,0,1));
        run_vec("mid.rst",   mk(1,0,0,0,0,8'h00,0,1,0,99, 1,1,  0,0,0));
        run_vec("mid.idle",  mk(0,0,0,0,0,8'h00,0,0,0,0,  1,0,  0,0,0));
        run_vec("mid.start2",mk(0,1,0,0,0,8'h00,0,0,0,0,  1,0,  0,0,0));
        run_vec("mid.ret1",  mk(0,0,0,0,0,8'h00,0,0,1,0,  1,1,  1,0,1));
        run_vec("mid.rsth",  mk(1,0,1,1,0,8'h00,0,0,0,0,  1,0,  0,0,0));
        run_vec("mid.idle2", mk(0,0,0,0,0,8'h00,0,0,0,0,  1,0,  0,0,0));

        // Random stimulus against the behavioural model.
        model_step(mk(1,0,0,0,0,8'h00,0,0,0,0, 0,0,0,0,0));
        run_vec("rnd.rst", mk(1,0,0,0,0,8'h00,0,0,0,0, 0,0, 0,0,0));
        for (int i = 0; i < 2000; i++) begin
            v = mk(($urandom_range(0, 63) == 0),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 31) == 0),
                   ($urandom_range(0, 3) == 0),
                   8'($urandom),
                   ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0),
                   int'($urandom_range(0, N - 1)),
                   1, 0, 0, 0, 0);
            v.ev = (m_st == 1) && !v.stall;
            model_step(v);
            v.ea = m_pc;
            v.ed = (m_st == 2);
            v.ee = m_err;
            run_vec($sformatf("rnd%0d", i), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
